timer_write_arbiter: RTL and testbench

Arbiter and sequencer for the bank of timer display registers. It shares the registers' write path between two requesters: the RTC read path (source 0) and the local count/edit path (source 1). For each request it drives the per-register `hold` lines and the shared `chip_select` so that exactly one register captures exactly one byte. The registers sample on the falling edge of `clk`; this block runs on the rising edge.

---
 rtl/timer_write_arbiter.sv | 132 +++++++++++++
 tb/tb_timer_write_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/timer_write_arbiter.sv
// Shares the timer display registers' write path between the RTC and count paths.
// Each grant opens exactly one register for one clock, then four-phase acks.
module timer_write_arbiter #(
  parameter int NREG = 3,
  parameter int FW   = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            lock,
  input  logic            rtc_req,
  input  logic [FW-1:0]   rtc_field,
  output logic            rtc_ack,
  input  logic            cnt_req,
  input  logic [FW-1:0]   cnt_field,
  output logic            cnt_ack,
  output logic [NREG-1:0] hold,
  output logic            chip_select,
  output logic            field_err,
  output logic            busy,
  output logic [7:0]      wr_count
);

  typedef enum logic [1:0] {IDLE, WRITE, ACK} state_e;

  localparam int unsigned NR = NREG;

  state_e          state_q, state_d;
  logic            src_q, src_d;
  logic [FW-1:0]   field_q, field_d;
  logic            prio_q, prio_d;
  logic            cs_q, cs_d;
  logic [NREG-1:0] hold_q, hold_d;
  logic            rack_q, rack_d;
  logic            cack_q, cack_d;
  logic            ferr_q, ferr_d;
  logic [7:0]      cnt_q, cnt_d;

  logic            gnt_src;
  logic [FW-1:0]   gnt_field;
  logic            gnt_ok;
  logic            fld_ok;
  logic            own_req;
  logic [NREG-1:0] gnt_mask;

  always_comb begin
    gnt_src   = (rtc_req && cnt_req) ? prio_q : cnt_req;
    gnt_field = gnt_src ? cnt_field : rtc_field;
    gnt_ok    = 32'(gnt_field) < NR;
    fld_ok    = 32'(field_q) < NR;
    own_req   = src_q ? cnt_req : rtc_req;
    for (int i = 0; i < NREG; i++) begin
      gnt_mask[i] = !(gnt_ok && (gnt_field == FW'(i)));
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    field_d = field_q;
    prio_d  = prio_q;
    cs_d    = cs_q;
    hold_d  = '1;
    rack_d  = rack_q;
    cack_d  = cack_q;
    ferr_d  = ferr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (!lock && (rtc_req || cnt_req)) begin
          state_d = WRITE;
          src_d   = gnt_src;
          field_d = gnt_field;
          cs_d    = gnt_src;
          hold_d  = gnt_mask;
        end
      end
      WRITE: begin
        state_d = ACK;
        rack_d  = !src_q;
        cack_d  = src_q;
        ferr_d  = !fld_ok;
        if (fld_ok) cnt_d = cnt_q + 8'd1;
      end
      ACK: begin
        // Four-phase: release only once the owner drops its request
        if (!own_req) begin
          state_d = IDLE;
          rack_d  = 1'b0;
          cack_d  = 1'b0;
          ferr_d  = 1'b0;
          prio_d  = !src_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      src_q   <= 1'b0;
      field_q <= '0;
      prio_q  <= 1'b0;
      cs_q    <= 1'b0;
      hold_q  <= '1;
      rack_q  <= 1'b0;
      cack_q  <= 1'b0;
      ferr_q  <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      field_q <= field_d;
      prio_q  <= prio_d;
      cs_q    <= cs_d;
      hold_q  <= hold_d;
      rack_q  <= rack_d;
      cack_q  <= cack_d;
      ferr_q  <= ferr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rtc_ack     = rack_q;
  assign cnt_ack     = cack_q;
  assign hold        = hold_q;
  assign chip_select = cs_q;
  assign field_err   = ferr_q;
  assign busy        = state_q != IDLE;
  assign wr_count    = cnt_q;

endmodule

// File: tb/tb_timer_write_arbiter.sv
// Bench for timer_write_arbiter: transaction-level model checked every cycle,
// directed scenarios with literal expectations, then randomized requesters.
module tb_timer_write_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       lock = 1'b0;
  logic       rtc_req = 1'b0;
  logic       cnt_req = 1'b0;
  logic [1:0] rtc_field = 2'd0;
  logic [1:0] cnt_field = 2'd0;
  logic       rtc_ack, cnt_ack, chip_select, field_err, busy;
  logic [2:0] hold;
  logic [7:0] wr_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  timer_write_arbiter #(.NREG(3), .FW(2)) dut (
    .clk(clk), .reset(reset), .lock(lock),
    .rtc_req(rtc_req), .rtc_field(rtc_field), .rtc_ack(rtc_ack),
    .cnt_req(cnt_req), .cnt_field(cnt_field), .cnt_ack(cnt_ack),
    .hold(hold), .chip_select(chip_select), .field_err(field_err),
    .busy(busy), .wr_count(wr_count)
  );

  task automatic cmp(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", n, $time, a, e);
    end
  endtask

  // Model: one open transaction with an owner, a field and its age in cycles
  // since the grant (age 1 = register open, age >= 2 = acknowledged).
  bit m_act = 0;
  int m_age = 0;
  bit m_who = 0;
  int m_fld = 0;
  bit m_ptr = 0;
  bit m_cs  = 0;
  int m_cnt = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_act = 0; m_age = 0; m_ptr = 0; m_cs = 0; m_cnt = 0;
    end else if (m_act) begin
      if (m_age >= 2 && !(m_who ? cnt_req : rtc_req)) begin
        m_act = 0;
        m_ptr = !m_who;
      end else if (m_age == 1) begin
        m_age = 2;
        if (m_fld < 3) m_cnt = (m_cnt + 1) % 256;
      end
    end else if (!lock && (rtc_req || cnt_req)) begin
      m_who = (rtc_req && cnt_req) ? m_ptr : cnt_req;
      m_fld = m_who ? int'(cnt_field) : int'(rtc_field);
      m_act = 1;
      m_age = 1;
      m_cs  = m_who;
    end
  end

  always @(negedge clk) begin : cmp_blk
    logic [2:0] eh;
    bit in_ack;
    eh = 3'b111;
    if (m_act && m_age == 1 && m_fld < 3) eh[m_fld] = 1'b0;
    in_ack = m_act && m_age >= 2;
    cmp("m_hold", hold, eh);
    cmp("m_cs", chip_select, m_cs);
    cmp("m_rtc_ack", rtc_ack, in_ack && !m_who);
    cmp("m_cnt_ack", cnt_ack, in_ack && m_who);
    cmp("m_field_err", field_err, in_ack && m_fld >= 3);
    cmp("m_busy", busy, m_act);
    cmp("m_wr_count", wr_count, m_cnt);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic do_write(input bit src, input logic [1:0] f);
    int n;
    if (src) begin cnt_field = f; cnt_req = 1'b1; end
    else begin rtc_field = f; rtc_req = 1'b1; end
    n = 0;
    while (!(src ? cnt_ack : rtc_ack) && n < 20) begin tick(); n++; end
    if (n >= 20) cmp("ack_wait", 0, 1);
    rtc_req = 1'b0;
    cnt_req = 1'b0;
    n = 0;
    while ((rtc_ack || cnt_ack) && n < 20) begin tick(); n++; end
    if (n >= 20) cmp("ack_drop", 0, 1);
  endtask

  initial begin
    tick(); tick();
    cmp("rst_hold", hold, 3'b111);
    cmp("rst_busy", busy, 0);
    cmp("rst_cs", chip_select, 0);
    cmp("rst_acks", {rtc_ack, cnt_ack, field_err}, 0);
    cmp("rst_count", wr_count, 0);
    reset = 1'b1;
    tick();

    // Single RTC write to minutes
    rtc_field = 2'd1; rtc_req = 1'b1;
    tick();
    cmp("t1_hold", hold, 3'b101);
    cmp("t1_cs", chip_select, 0);
    tick();
    cmp("t1_ack", rtc_ack, 1);
    cmp("t1_count", wr_count, 1);
    cmp("t1_hold_ack", hold, 3'b111);
    tick();
    cmp("t1_ack_held", rtc_ack, 1);
    rtc_req = 1'b0;
    tick();
    cmp("t1_ack_drop", rtc_ack, 0);

    // Simultaneous requests after reset: RTC first, then count
    pulse_reset();
    rtc_field = 2'd0; cnt_field = 2'd2;
    rtc_req = 1'b1; cnt_req = 1'b1;
    tick();
    cmp("t2_hold_rtc", hold, 3'b110);
    cmp("t2_cs_rtc", chip_select, 0);
    tick();
    cmp("t2_rtc_ack", rtc_ack, 1);
    rtc_req = 1'b0;
    tick();
    tick();
    cmp("t2_hold_cnt", hold, 3'b011);
    cmp("t2_cs_cnt", chip_select, 1);
    tick();
    cmp("t2_cnt_ack", cnt_ack, 1);
    cmp("t2_count", wr_count, 2);
    cnt_req = 1'b0;
    tick();

    // Invalid field
    cnt_field = 2'd3; cnt_req = 1'b1;
    tick();
    cmp("t3_hold", hold, 3'b111);
    cmp("t3_busy", busy, 1);
    tick();
    cmp("t3_ack", cnt_ack, 1);
    cmp("t3_ferr", field_err, 1);
    cmp("t3_count", wr_count, 2);
    cnt_req = 1'b0;
    tick();
    cmp("t3_ferr_drop", field_err, 0);

    // Lock blocks grants
    lock = 1'b1; rtc_field = 2'd0; rtc_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      cmp("t4_locked_busy", busy, 0);
    end
    lock = 1'b0;
    tick();
    cmp("t4_busy", busy, 1);
    cmp("t4_hold", hold, 3'b110);
    tick();
    cmp("t4_count", wr_count, 3);
    rtc_req = 1'b0;
    tick();

    // Reset during WRITE
    rtc_field = 2'd2; rtc_req = 1'b1;
    tick();
    cmp("t5_hold_pre", hold, 3'b011);
    #2 reset = 1'b0;
    #1;
    cmp("t5_hold", hold, 3'b111);
    cmp("t5_ack", rtc_ack, 0);
    cmp("t5_count", wr_count, 0);
    #2 reset = 1'b1;
    tick();
    cmp("t5_regrant", hold, 3'b011);
    tick();
    cmp("t5_count2", wr_count, 1);
    rtc_req = 1'b0;
    tick();

    // Counter wrap
    pulse_reset();
    for (int i = 0; i < 256; i++) begin
      do_write(i[0], 2'(i % 3));
      if (i == 254) cmp("t6_count255", wr_count, 255);
    end
    cmp("t6_wrap", wr_count, 0);

    // Randomized four-phase requesters with random lock
    for (int c = 0; c < 3000; c++) begin
      lock = ($urandom_range(0, 9) == 0);
      if (rtc_req) begin
        if (rtc_ack && $urandom_range(0, 1) == 1) rtc_req = 1'b0;
      end else if (!rtc_ack && $urandom_range(0, 2) == 0) begin
        rtc_field = 2'($urandom_range(0, 3));
        rtc_req = 1'b1;
      end
      if (cnt_req) begin
        if (cnt_ack && $urandom_range(0, 1) == 1) cnt_req = 1'b0;
      end else if (!cnt_ack && $urandom_range(0, 2) == 0) begin
        cnt_field = 2'($urandom_range(0, 3));
        cnt_req = 1'b1;
      end
      tick();
    end
    rtc_req = 1'b0; cnt_req = 1'b0; lock = 1'b0;
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
